pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed-width, always-load stage latches with a single reusable stage. The stage carries one payload word and one exception vector with a valid/ready handshake and an optional skid entry, so that a stage can stall without a combinational ready path crossing the boundary. A flush input squashes the stage contents to an all-zero bubble, which the core decodes as a NOP. Every stage boundary instantiates it: IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- PAYLOAD_W, 32: width of the concatenated stage payload (instruction, operands, PC, etc.); minimum 1
- EXC_W, 6: width of the exception-code vector carried alongside the payload
- SKID, 1: 1 gives a two-entry stage with registered in_ready; 0 gives a single entry whose in_ready depends combinationally on out_ready
- CNT_W, 16: width of the stall-cycle counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  upstream stage offers a transfer
- in_ready  out  1  stage will accept a transfer this cycle
- in_data  in  PAYLOAD_W  upstream payload
- in_exc  in  EXC_W  upstream exception vector
- out_valid  out  1  stage holds a valid entry for downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  PAYLOAD_W  head-entry payload
- out_exc  out  EXC_W  head-entry exception vector
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Upstream transfer occurs when in_valid && in_ready; downstream transfer occurs when out_valid && out_ready.
- SKID=1 state machine, with out_data/out_exc always driven from the main entry:
  - EMPTY: in_ready=1. An upstream transfer loads main and moves to ONE.
  - ONE: in_ready=1.
    - Simultaneous upstream and downstream transfers reload main and stay in ONE.
    - A downstream transfer alone moves to EMPTY.
    - An upstream transfer alone loads the skid entry and moves to FULL.
  - FULL: in_ready=0. A downstream transfer moves skid into main and returns to ONE.
- SKID=0: single entry. in_ready = !out_valid || out_ready. The entry loads on each upstream transfer; otherwise out_valid clears on a downstream transfer.
- flush, from any state: next state EMPTY, and main/skid payload and exc are cleared to 0. flush has priority over any same-cycle transfer on either side. The upstream word offered in the flush cycle is dropped, even though in_ready may read 1.
- rst has the same effect as flush and additionally clears stall_cnt to 0.
- While rst is high, in_ready is forced to 0.
- stall_cnt increments by 1 on each cycle where out_valid && !out_ready && !flush. It saturates at 2^CNT_W-1 and never wraps.
- No reordering: entries leave in arrival order. The payload is never modified.

## Timing
- Reset values after the first clk edge with rst=1: out_valid=0, out_data=0, out_exc=0, stall_cnt=0.
- With rst=0 and SKID=1, in_ready=1 in the first cycle after reset deasserts.
- Latency is one cycle: data accepted at edge N appears on out_data after edge N with out_valid=1.
- Throughput is one transfer per cycle with continuous out_ready=1.
- SKID=1: in_ready is a pure register output with no combinational path from out_ready.
- SKID=0: there is a combinational path from out_ready to in_ready.
- A flush at edge N makes out_valid=0 and out_data=0 visible after edge N.
- Upstream must hold in_data and in_exc stable while in_valid && !in_ready.

## Structure
- A shared package cpu_pipe_pkg holds:
  - the stage state encoding (ST_EMPTY, ST_ONE, ST_FULL);
  - the default EXC_W;
  - the zero-bubble constant convention.
- One sub-module, pipe_entry_reg: a single PAYLOAD_W+EXC_W register with load and clear enables. It is instantiated once for main and, when SKID=1, once for skid.
- The state machine and stall counter stay in the top module.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 -> in_ready=0 throughout; afterwards out_valid=0, out_data=0, stall_cnt=0.
- Streaming (SKID=1): send 0x1..0x8 with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, each one cycle after input, in_ready stays 1.
- Backpressure: out_ready=0 while sending 0xA, 0xB, 0xC -> state reaches FULL, in_ready=0, 0xC held upstream; release out_ready -> outputs 0xA, 0xB, 0xC in order, nothing lost; stall_cnt equals the stalled cycles.
- Flush in FULL with simultaneous in_valid=1 carrying 0xD -> next cycle out_valid=0, out_data=0, out_exc=0; 0xD never appears at the output.
- stall_cnt saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15.
- SKID=0: same stream with out_ready toggling 1,0,1,0 -> in_ready follows out_ready while the entry is occupied; output order is preserved.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the MIPS core's inter-stage pipeline registers:
// stage occupancy encoding, default exception width and the bubble fill value.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam int DEF_EXC_W = 6;

  // A squashed entry is all zeros, which the decoder treats as a NOP.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage entry (payload + exception vector) with clear and load enables.
// Clear wins over load so a flush always leaves a clean bubble.
module pipe_entry_reg
  import cpu_pipe_pkg::*;
#(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= {W{BUBBLE_BIT}};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, optional skid
// entry, flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int EXC_W     = DEF_EXC_W,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [EXC_W-1:0]     in_exc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [EXC_W-1:0]     out_exc,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int ENTRY_W = PAYLOAD_W + EXC_W;

  stage_state_t        state;
  stage_state_t        state_next;
  logic                clear;
  logic                up;
  logic                dn;
  logic                main_load;
  logic                skid_load;
  logic [ENTRY_W-1:0]  in_entry;
  logic [ENTRY_W-1:0]  main_d;
  logic [ENTRY_W-1:0]  main_q;
  logic [ENTRY_W-1:0]  skid_q;

  assign clear    = rst | flush;
  assign up       = in_valid & in_ready;
  assign dn       = out_valid & out_ready;
  assign in_entry = {in_exc, in_data};

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (SKID != 0) begin
      case (state)
        ST_EMPTY: if (up) state_next = ST_ONE;
        ST_ONE: begin
          if (dn && !up)      state_next = ST_EMPTY;
          else if (up && !dn) state_next = ST_FULL;
        end
        ST_FULL:  if (dn) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end else begin
      case (state)
        ST_EMPTY, ST_ONE: begin
          if (up)      state_next = ST_ONE;
          else if (dn) state_next = ST_EMPTY;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // With a skid entry in_ready decodes registered state only; without one it
  // looks through to out_ready so a full single entry can drain and refill.
  always_comb begin
    out_valid = (state != ST_EMPTY);
    if (SKID != 0) begin
      in_ready = !rst && (state != ST_FULL);
    end else begin
      in_ready = !rst && (!out_valid || out_ready);
    end
  end

  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    if (SKID != 0) begin
      case (state)
        ST_EMPTY: main_load = up;
        ST_ONE: begin
          main_load = up && dn;
          skid_load = up && !dn;
        end
        ST_FULL: begin
          main_load = dn;
          main_d    = skid_q;
        end
        default: main_load = 1'b0;
      endcase
    end else begin
      main_load = up;
    end
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .clear (clear),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk   (clk),
        .clear (clear),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  assign out_data = main_q[PAYLOAD_W-1:0];
  assign out_exc  = main_q[ENTRY_W-1:PAYLOAD_W];

  // Counts stalled cycles; a flush cycle is not a stall, and the count pins at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid
// instance, each with an in-order scoreboard fed by accepted upstream words.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] in_data;
  logic [5:0]  in_exc;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_out_data;
  logic [5:0]  a_out_exc;
  logic [3:0]  a_stall_cnt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_out_data;
  logic [5:0]  b_out_exc;
  logic [15:0] b_stall_cnt;

  int checks = 0;
  int errors = 0;
  int a_popped = 0;
  int b_popped = 0;
  logic [37:0] qa[$];
  logic [37:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.PAYLOAD_W(32), .EXC_W(6), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_exc(in_exc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_exc(a_out_exc), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(.PAYLOAD_W(32), .EXC_W(6), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_exc(in_exc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_exc(b_out_exc), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v);
    in_data = v;
    in_exc  = v[5:0];
  endtask

  // Scoreboards: pop before push so a same-cycle pass-through stays in order.
  always @(negedge clk) begin
    if (rst || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        check("a_sb_occupancy", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) check("a_sb_order", {a_out_exc, a_out_data}, qa.pop_front());
        a_popped++;
      end
      if (a_in_valid && a_in_ready) qa.push_back({in_exc, in_data});
      if (b_out_valid && b_out_ready) begin
        check("b_sb_occupancy", 64'(qb.size() > 0), 64'd1);
        if (qb.size() > 0) check("b_sb_order", {b_out_exc, b_out_data}, qb.pop_front());
        b_popped++;
      end
      if (b_in_valid && b_in_ready) qb.push_back({in_exc, in_data});
    end
  end

  initial begin
    int idx;
    int cyc;
    logic occ;
    logic acc;

    rst = 1'b1; flush = 1'b0; drive(32'h5A);
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_out_ready = 1'b0;

    // Reset held two cycles with in_valid high
    #1;
    check("rst_a_in_ready_0", a_in_ready, 0);
    check("rst_b_in_ready_0", b_in_ready, 0);
    tick();
    check("rst_a_in_ready_1", a_in_ready, 0);
    check("rst_b_in_ready_1", b_in_ready, 0);
    tick();
    check("rst_a_in_ready_2", a_in_ready, 0);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_out_exc", a_out_exc, 0);
    check("rst_a_stall_cnt", a_stall_cnt, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_stall_cnt", b_stall_cnt, 0);
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    check("post_rst_a_in_ready", a_in_ready, 1);

    // Streaming through the skid stage
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(i); a_in_valid = 1'b1;
      tick();
      check("stream_out_valid", a_out_valid, 1);
      check("stream_out_data", a_out_data, 64'(i));
      check("stream_out_exc", a_out_exc, 64'(i));
      check("stream_in_ready", a_in_ready, 1);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drained", a_out_valid, 0);
    check("stream_no_stall", a_stall_cnt, 0);

    // Backpressure into FULL, then release
    a_out_ready = 1'b0;
    drive(32'hA); a_in_valid = 1'b1;
    tick();
    check("bp_a_loaded", a_out_data, 64'hA);
    check("bp_ready_one", a_in_ready, 1);
    drive(32'hB);
    tick();
    check("bp_full_ready", a_in_ready, 0);
    check("bp_head_a", a_out_data, 64'hA);
    check("bp_stall_1", a_stall_cnt, 1);
    drive(32'hC);
    tick();
    check("bp_full_hold", a_in_ready, 0);
    tick();
    check("bp_stall_3", a_stall_cnt, 3);
    check("bp_head_still_a", a_out_data, 64'hA);
    a_out_ready = 1'b1;
    tick();
    check("bp_head_b", a_out_data, 64'hB);
    check("bp_ready_after_drain", a_in_ready, 1);
    tick();
    check("bp_head_c", a_out_data, 64'hC);
    a_in_valid = 1'b0;
    tick();
    check("bp_empty", a_out_valid, 0);
    check("bp_stall_final", a_stall_cnt, 3);

    // Flush while FULL with a word offered upstream
    a_out_ready = 1'b0;
    drive(32'h11); a_in_valid = 1'b1;
    tick();
    drive(32'h12);
    tick();
    check("fl_full", a_in_ready, 0);
    drive(32'hD); flush = 1'b1;
    tick();
    check("fl_out_valid", a_out_valid, 0);
    check("fl_out_data", a_out_data, 0);
    check("fl_out_exc", a_out_exc, 0);
    flush = 1'b0; a_in_valid = 1'b0;
    tick();
    check("fl_no_d", a_out_valid, 0);
    check("fl_no_d_data", a_out_data, 0);
    check("fl_in_ready", a_in_ready, 1);
    check("fl_stall_cnt", a_stall_cnt, 4);

    // Saturation of the 4-bit stall counter
    drive(32'h20); a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    repeat (20) tick();
    check("sat_stall_cnt", a_stall_cnt, 15);
    check("sat_head_kept", a_out_data, 64'h20);
    a_out_ready = 1'b1;
    tick();
    check("sat_drained", a_out_valid, 0);
    check("sat_cnt_held", a_stall_cnt, 15);
    check("a_total_out", a_popped, 12);
    check("a_sb_empty", qa.size(), 0);

    // Single-entry stage with toggling out_ready
    idx = 1; cyc = 0; occ = 1'b0;
    while (idx <= 8 && cyc < 64) begin
      drive(idx); b_in_valid = 1'b1;
      b_out_ready = (cyc % 2 == 0);
      #1;
      check("ns_out_valid", b_out_valid, 64'(occ));
      check("ns_in_ready", b_in_ready, 64'(!occ || b_out_ready));
      acc = !occ || b_out_ready;
      if (acc) idx++;
      occ = acc ? 1'b1 : (b_out_ready ? 1'b0 : occ);
      tick();
      cyc++;
    end
    check("ns_no_timeout", 64'(idx), 64'd9);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    tick();
    check("ns_drained", b_out_valid, 0);
    check("b_total_out", b_popped, 8);
    check("b_sb_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
